avalon_mm_pipe_bridge: RTL and testbench

- Parametrised Avalon-MM pipeline bridge for the SoC interconnect, successor to the fixed 32-bit, 28-bit-address, single-beat mm_bridge slave.
- Sits between the processor-side master and the system fabric.
- Registers command and response paths for timing closure and supports bursts.
- Bounds outstanding read words with a pending-read limit, so no response buffering is ever needed.

---
 rtl/avalon_mm_pipe_bridge.sv | 193 +++++++++++++++++++
 tb/tb_avalon_mm_pipe_bridge.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_mm_pipe_bridge.sv
// Avalon-MM pipeline bridge: 2-entry registered command FIFO, 1-stage response register,
// pending-read limiter. Define AVMM_BRIDGE_TIMEOUT_EN to enable the read-response timeout.
module avalon_mm_pipe_bridge #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 28,
  parameter int BURST_W     = 1,
  parameter int MAX_PENDING = 8,
  parameter int TIMEOUT     = 1024
) (
  input  logic                               clk_clk,
  input  logic                               reset_reset_n,
  output logic                               s_waitrequest,
  output logic [DATA_W-1:0]                  s_readdata,
  output logic                               s_readdatavalid,
  input  logic [BURST_W-1:0]                 s_burstcount,
  input  logic [DATA_W-1:0]                  s_writedata,
  input  logic [ADDR_W-1:0]                  s_address,
  input  logic                               s_write,
  input  logic                               s_read,
  input  logic [DATA_W/8-1:0]                s_byteenable,
  input  logic                               s_debugaccess,
  input  logic                               m_waitrequest,
  input  logic [DATA_W-1:0]                  m_readdata,
  input  logic                               m_readdatavalid,
  output logic [BURST_W-1:0]                 m_burstcount,
  output logic [DATA_W-1:0]                  m_writedata,
  output logic [ADDR_W-1:0]                  m_address,
  output logic                               m_write,
  output logic                               m_read,
  output logic [DATA_W/8-1:0]                m_byteenable,
  output logic                               m_debugaccess,
  output logic [$clog2(MAX_PENDING+1)-1:0]   pend_cnt,
  output logic                               rsp_err
);

  localparam int BE_W = DATA_W / 8;
  localparam int MAXB = 1 << (BURST_W - 1);
  localparam int PW   = $clog2(MAX_PENDING + 1);
  localparam logic [PW-1:0] PEND_LIMIT = PW'(MAX_PENDING - MAXB);

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [BURST_W-1:0] bc;
    logic [DATA_W-1:0]  wdata;
    logic [BE_W-1:0]    be;
    logic               dbg;
    logic               rd;
    logic               wr;
  } cmd_t;

  function automatic logic [BURST_W-1:0] eff_burst(input logic [BURST_W-1:0] bc);
    return (bc == '0) ? BURST_W'(1) : bc;
  endfunction

  // Counter never wraps below zero: a stray response at zero leaves it at zero.
  function automatic logic [PW-1:0] pend_update(input logic [PW-1:0] cur,
                                                 input logic inc_en,
                                                 input logic [BURST_W-1:0] bc,
                                                 input logic dec_en);
    logic [PW-1:0] v;
    v = cur + (inc_en ? PW'(bc) : '0);
    if (dec_en && (cur != '0))
      v = v - PW'(1);
    return v;
  endfunction

  cmd_t           fifo_mem [2];
  logic [1:0]     fifo_cnt;
  logic           wr_ptr;
  logic           rd_ptr;
  logic [PW-1:0]  pend_q;
  logic           wait_q;
  logic           rvld_p1;
  logic [DATA_W-1:0] rdata_p1;

  logic           accept;
  logic           accept_rd;
  logic           head_vld;
  logic           pop;
  cmd_t           head;
  cmd_t           push_cmd;
  logic [1:0]     cnt_next;
  logic [PW-1:0]  pend_next;
  logic           fire;
  logic           drop;
  logic [DATA_W-1:0] rsp_data;

  // Stage p0: slave-side accept
  assign accept    = (s_read | s_write) & ~wait_q;
  assign accept_rd = accept & s_read;

  always_comb begin
    push_cmd       = '0;
    push_cmd.addr  = s_address;
    push_cmd.bc    = eff_burst(s_burstcount);
    push_cmd.wdata = s_writedata;
    push_cmd.be    = s_byteenable;
    push_cmd.dbg   = s_debugaccess;
    push_cmd.rd    = s_read;
    push_cmd.wr    = s_write & ~s_read;
  end

  // Stage p1: FIFO head drives the fabric
  assign head_vld = (fifo_cnt != 2'd0);
  assign head     = fifo_mem[rd_ptr];
  assign pop      = head_vld & ~m_waitrequest;
  assign cnt_next = fifo_cnt + {1'b0, accept} - {1'b0, pop};

  assign m_read        = head_vld & head.rd;
  assign m_write       = head_vld & head.wr;
  assign m_address     = head_vld ? head.addr  : '0;
  assign m_burstcount  = head_vld ? head.bc    : '0;
  assign m_writedata   = head_vld ? head.wdata : '0;
  assign m_byteenable  = head_vld ? head.be    : '0;
  assign m_debugaccess = head_vld & head.dbg;

  assign pend_next = pend_update(pend_q, accept_rd, push_cmd.bc, m_readdatavalid | fire);

  always_ff @(posedge clk_clk) begin
    if (accept)
      fifo_mem[wr_ptr] <= push_cmd;
  end

`ifdef AVMM_BRIDGE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [31:0] TIMEOUT_PAT = 32'hDEADBEEF;

  function automatic logic [DATA_W-1:0] timeout_word();
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W; i++)
      r[i] = TIMEOUT_PAT[i % 32];
    return r;
  endfunction

  logic [TW-1:0] timer;
  logic          err_q;

  assign fire     = (pend_q != '0) & ~m_readdatavalid & (timer == TW'(TIMEOUT - 1));
  assign drop     = err_q & (pend_q == '0);
  assign rsp_data = fire ? timeout_word() : m_readdata;
  assign rsp_err  = err_q;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      timer <= '0;
      err_q <= 1'b0;
    end else begin
      if (m_readdatavalid || (pend_q == '0) || fire)
        timer <= '0;
      else
        timer <= timer + TW'(1);
      if (fire)
        err_q <= 1'b1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
  assign fire     = 1'b0;
  assign drop     = 1'b0;
  assign rsp_data = m_readdata;
  assign rsp_err  = 1'b0;
`endif

  // Stage p1: registered control and response
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      fifo_cnt <= 2'd0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      pend_q   <= '0;
      wait_q   <= 1'b1;
      rvld_p1  <= 1'b0;
      rdata_p1 <= '0;
    end else begin
      fifo_cnt <= cnt_next;
      if (accept)
        wr_ptr <= ~wr_ptr;
      if (pop)
        rd_ptr <= ~rd_ptr;
      pend_q   <= pend_next;
      wait_q   <= (cnt_next == 2'd2) | (pend_next > PEND_LIMIT);
      rvld_p1  <= (m_readdatavalid & ~drop) | fire;
      rdata_p1 <= rsp_data;
    end
  end

  assign s_waitrequest   = wait_q;
  assign s_readdatavalid = rvld_p1;
  assign s_readdata      = rdata_p1;
  assign pend_cnt        = pend_q;

endmodule

// File: tb/tb_avalon_mm_pipe_bridge.sv
// Directed bench for avalon_mm_pipe_bridge (BURST_W=3, MAX_PENDING=8, TIMEOUT=16).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_avalon_mm_pipe_bridge;
  localparam int DW = 32, AW = 28, BW = 3, MP = 8, TO = 16, PW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic s_waitrequest, s_readdatavalid, s_write, s_read, s_debugaccess;
  logic [DW-1:0] s_readdata, s_writedata, m_readdata, m_writedata;
  logic [BW-1:0] s_burstcount, m_burstcount;
  logic [AW-1:0] s_address, m_address;
  logic [3:0] s_byteenable, m_byteenable;
  logic m_waitrequest, m_readdatavalid, m_write, m_read, m_debugaccess, rsp_err;
  logic [PW-1:0] pend_cnt;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  avalon_mm_pipe_bridge #(.DATA_W(DW), .ADDR_W(AW), .BURST_W(BW), .MAX_PENDING(MP), .TIMEOUT(TO)) dut (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
    .s_burstcount(s_burstcount), .s_writedata(s_writedata), .s_address(s_address),
    .s_write(s_write), .s_read(s_read), .s_byteenable(s_byteenable), .s_debugaccess(s_debugaccess),
    .m_waitrequest(m_waitrequest), .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
    .m_burstcount(m_burstcount), .m_writedata(m_writedata), .m_address(m_address),
    .m_write(m_write), .m_read(m_read), .m_byteenable(m_byteenable), .m_debugaccess(m_debugaccess),
    .pend_cnt(pend_cnt), .rsp_err(rsp_err)
  );

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (s_waitrequest !== 1'b1) begin bad++; $display("FAIL rst_wait got=%b want=1", s_waitrequest); end
    total++; if (pend_cnt !== 4'd0) begin bad++; $display("FAIL rst_pend got=%0d want=0", pend_cnt); end
    total++; if (m_read !== 1'b0 || m_write !== 1'b0) begin bad++; $display("FAIL rst_mcmd got=%b%b want=00", m_read, m_write); end
    total++; if (s_readdatavalid !== 1'b0 || s_readdata !== 32'h0) begin bad++; $display("FAIL rst_rsp got=%b/%h want=0/0", s_readdatavalid, s_readdata); end
    total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b want=0", rsp_err); end
    rst_n = 1'b1;
    #1;
    total++; if (s_waitrequest !== 1'b1) begin bad++; $display("FAIL rst_release_wait got=%b want=1", s_waitrequest); end
    @(negedge clk);
    total++; if (s_waitrequest !== 1'b0) begin bad++; $display("FAIL rst_after_edge_wait got=%b want=0", s_waitrequest); end
  endtask

  task automatic test_write();
    s_write = 1'b1; s_address = 28'h0000010; s_writedata = 32'h12345678;
    s_byteenable = 4'hF; s_burstcount = 3'd1; s_debugaccess = 1'b1; m_waitrequest = 1'b0;
    @(negedge clk);
    s_write = 1'b0; s_debugaccess = 1'b0;
    total++; if (m_write !== 1'b1 || m_read !== 1'b0) begin bad++; $display("FAIL wr_cmd got=%b%b want=10", m_write, m_read); end
    total++; if (m_address !== 28'h0000010) begin bad++; $display("FAIL wr_addr got=%h want=0000010", m_address); end
    total++; if (m_writedata !== 32'h12345678) begin bad++; $display("FAIL wr_data got=%h want=12345678", m_writedata); end
    total++; if (m_byteenable !== 4'hF || m_burstcount !== 3'd1) begin bad++; $display("FAIL wr_be_bc got=%h/%0d want=f/1", m_byteenable, m_burstcount); end
    total++; if (m_debugaccess !== 1'b1) begin bad++; $display("FAIL wr_dbg got=%b want=1", m_debugaccess); end
    total++; if (pend_cnt !== 4'd0) begin bad++; $display("FAIL wr_pend got=%0d want=0", pend_cnt); end
    @(negedge clk);
    total++; if (m_write !== 1'b0) begin bad++; $display("FAIL wr_pop got=%b want=0", m_write); end
    // two-beat write burst
    s_write = 1'b1; s_burstcount = 3'd2; s_address = 28'h20; s_writedata = 32'h000000A1; s_byteenable = 4'h3;
    @(negedge clk);
    total++; if (m_write !== 1'b1 || m_writedata !== 32'hA1 || m_burstcount !== 3'd2) begin bad++; $display("FAIL wrb_beat0 got=%b/%h/%0d want=1/a1/2", m_write, m_writedata, m_burstcount); end
    s_writedata = 32'h000000A2;
    @(negedge clk);
    s_write = 1'b0;
    total++; if (m_write !== 1'b1 || m_writedata !== 32'hA2 || m_burstcount !== 3'd2) begin bad++; $display("FAIL wrb_beat1 got=%b/%h/%0d want=1/a2/2", m_write, m_writedata, m_burstcount); end
    @(negedge clk);
    total++; if (m_write !== 1'b0 || pend_cnt !== 4'd0) begin bad++; $display("FAIL wrb_end got=%b/%0d want=0/0", m_write, pend_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] addrs [4];
    int idx, got, hold, cyc;
    logic saw_stall;
    addrs[0] = 28'h100; addrs[1] = 28'h104; addrs[2] = 28'h108; addrs[3] = 28'h10C;
    idx = 0; got = 0; hold = 0; cyc = 0; saw_stall = 1'b0;
    s_burstcount = 3'd1; s_byteenable = 4'hF;
    while (got < 4 && cyc < 30) begin
      if (m_read) begin
        if (hold < 3) begin m_waitrequest = 1'b1; hold++; end
        else m_waitrequest = 1'b0;
        if (!m_waitrequest) begin
          total++; if (m_address !== addrs[got]) begin bad++; $display("FAIL b2b_order%0d got=%h want=%h", got, m_address, addrs[got]); end
          got++;
        end
      end
      if (s_waitrequest) saw_stall = 1'b1;
      if (idx < 4) begin
        s_read = 1'b1; s_address = addrs[idx];
        if (!s_waitrequest) idx++;
      end else s_read = 1'b0;
      @(negedge clk);
      cyc++;
    end
    s_read = 1'b0; m_waitrequest = 1'b0;
    total++; if (got !== 4) begin bad++; $display("FAIL b2b_count got=%0d want=4", got); end
    total++; if (saw_stall !== 1'b1) begin bad++; $display("FAIL b2b_stall got=%b want=1", saw_stall); end
    total++; if (m_read !== 1'b0 || pend_cnt !== 4'd4) begin bad++; $display("FAIL b2b_idle got=%b/%0d want=0/4", m_read, pend_cnt); end
    for (int i = 0; i <= 4; i++) begin
      if (i < 4) begin m_readdatavalid = 1'b1; m_readdata = 32'hA0000000 + i; end
      else m_readdatavalid = 1'b0;
      @(negedge clk);
      if (i < 4) begin
        total++; if (s_readdatavalid !== 1'b1 || s_readdata !== 32'hA0000000 + i) begin bad++; $display("FAIL b2b_rsp%0d got=%b/%h want=1/%h", i, s_readdatavalid, s_readdata, 32'hA0000000 + i); end
      end
    end
    total++; if (pend_cnt !== 4'd0 || s_waitrequest !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%0d/%b want=0/0", pend_cnt, s_waitrequest); end
  endtask

  task automatic test_burst_limit();
    logic exp_w;
    s_read = 1'b1; s_burstcount = 3'd4; s_address = 28'h200;
    @(negedge clk);
    total++; if (pend_cnt !== 4'd4 || s_waitrequest !== 1'b0) begin bad++; $display("FAIL bl_first got=%0d/%b want=4/0", pend_cnt, s_waitrequest); end
    s_address = 28'h204;
    @(negedge clk);
    s_address = 28'h208;
    total++; if (pend_cnt !== 4'd8 || s_waitrequest !== 1'b1) begin bad++; $display("FAIL bl_second got=%0d/%b want=8/1", pend_cnt, s_waitrequest); end
    total++; if (m_read !== 1'b1 || m_address !== 28'h204 || m_burstcount !== 3'd4) begin bad++; $display("FAIL bl_fwd got=%b/%h/%0d want=1/204/4", m_read, m_address, m_burstcount); end
    for (int i = 0; i < 4; i++) begin
      m_readdatavalid = 1'b1; m_readdata = 32'hB0000000 + i;
      @(negedge clk);
      exp_w = ((7 - i) > 4);
      total++; if (s_readdatavalid !== 1'b1 || s_readdata !== 32'hB0000000 + i) begin bad++; $display("FAIL bl_rsp%0d got=%b/%h want=1/%h", i, s_readdatavalid, s_readdata, 32'hB0000000 + i); end
      total++; if (pend_cnt !== 4'(7 - i) || s_waitrequest !== exp_w) begin bad++; $display("FAIL bl_hold%0d got=%0d/%b want=%0d/%b", i, pend_cnt, s_waitrequest, 7 - i, exp_w); end
    end
    m_readdatavalid = 1'b0;
    @(negedge clk);
    s_read = 1'b0;
    total++; if (pend_cnt !== 4'd8 || s_waitrequest !== 1'b1 || s_readdatavalid !== 1'b0) begin bad++; $display("FAIL bl_third got=%0d/%b/%b want=8/1/0", pend_cnt, s_waitrequest, s_readdatavalid); end
    total++; if (m_read !== 1'b1 || m_address !== 28'h208) begin bad++; $display("FAIL bl_third_fwd got=%b/%h want=1/208", m_read, m_address); end
    for (int j = 0; j < 8; j++) begin
      m_readdatavalid = 1'b1; m_readdata = 32'hC0000000 + j;
      @(negedge clk);
    end
    m_readdatavalid = 1'b0;
    total++; if (pend_cnt !== 4'd0 || s_waitrequest !== 1'b0) begin bad++; $display("FAIL bl_drain got=%0d/%b want=0/0", pend_cnt, s_waitrequest); end
  endtask

  task automatic test_simultaneous();
    s_read = 1'b1; s_burstcount = 3'd3; s_address = 28'h300;
    @(negedge clk);
    total++; if (pend_cnt !== 4'd3) begin bad++; $display("FAIL sim_pre got=%0d want=3", pend_cnt); end
    s_burstcount = 3'd2; s_address = 28'h304;
    m_readdatavalid = 1'b1; m_readdata = 32'h000000D0;
    @(negedge clk);
    s_read = 1'b0; m_readdatavalid = 1'b0;
    total++; if (pend_cnt !== 4'd4) begin bad++; $display("FAIL sim_pend got=%0d want=4", pend_cnt); end
    total++; if (s_readdatavalid !== 1'b1 || s_readdata !== 32'hD0) begin bad++; $display("FAIL sim_rsp got=%b/%h want=1/d0", s_readdatavalid, s_readdata); end
    repeat (4) begin
      m_readdatavalid = 1'b1;
      @(negedge clk);
    end
    m_readdatavalid = 1'b0;
    total++; if (pend_cnt !== 4'd0) begin bad++; $display("FAIL sim_drain got=%0d want=0", pend_cnt); end
  endtask

  task automatic test_edge_cases();
    m_readdatavalid = 1'b1; m_readdata = 32'h55AA55AA;
    @(negedge clk);
    m_readdatavalid = 1'b0;
    total++; if (s_readdatavalid !== 1'b1 || s_readdata !== 32'h55AA55AA) begin bad++; $display("FAIL stray_rsp got=%b/%h want=1/55aa55aa", s_readdatavalid, s_readdata); end
    total++; if (pend_cnt !== 4'd0) begin bad++; $display("FAIL stray_pend got=%0d want=0", pend_cnt); end
    s_read = 1'b1; s_write = 1'b1; s_burstcount = 3'd0; s_address = 28'h400;
    @(negedge clk);
    s_read = 1'b0; s_write = 1'b0;
    total++; if (m_read !== 1'b1 || m_write !== 1'b0) begin bad++; $display("FAIL rw_as_read got=%b%b want=10", m_read, m_write); end
    total++; if (m_burstcount !== 3'd1 || pend_cnt !== 4'd1) begin bad++; $display("FAIL bc0 got=%0d/%0d want=1/1", m_burstcount, pend_cnt); end
    m_readdatavalid = 1'b1;
    @(negedge clk);
    m_readdatavalid = 1'b0;
    total++; if (pend_cnt !== 4'd0) begin bad++; $display("FAIL bc0_drain got=%0d want=0", pend_cnt); end
  endtask

`ifdef AVMM_BRIDGE_TIMEOUT_EN
  task automatic test_timeout();
    int cyc;
    total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL to_pre_err got=%b want=0", rsp_err); end
    s_read = 1'b1; s_burstcount = 3'd1; s_address = 28'h500;
    @(negedge clk);
    s_read = 1'b0;
    cyc = 0;
    while (cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (s_readdatavalid) break;
    end
    total++; if (cyc !== 16) begin bad++; $display("FAIL to_latency got=%0d want=16", cyc); end
    total++; if (s_readdatavalid !== 1'b1 || s_readdata !== 32'hDEADBEEF) begin bad++; $display("FAIL to_data got=%b/%h want=1/deadbeef", s_readdatavalid, s_readdata); end
    total++; if (pend_cnt !== 4'd0 || rsp_err !== 1'b1) begin bad++; $display("FAIL to_state got=%0d/%b want=0/1", pend_cnt, rsp_err); end
    m_readdatavalid = 1'b1; m_readdata = 32'h11111111;
    @(negedge clk);
    m_readdatavalid = 1'b0;
    total++; if (s_readdatavalid !== 1'b0 || pend_cnt !== 4'd0) begin bad++; $display("FAIL to_late_drop got=%b/%0d want=0/0", s_readdatavalid, pend_cnt); end
    @(negedge clk);
    total++; if (rsp_err !== 1'b1) begin bad++; $display("FAIL to_err_held got=%b want=1", rsp_err); end
  endtask
`else
  task automatic test_no_timeout();
    logic seen;
    seen = 1'b0;
    s_read = 1'b1; s_burstcount = 3'd1; s_address = 28'h500;
    @(negedge clk);
    s_read = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (s_readdatavalid) seen = 1'b1;
    end
    total++; if (seen !== 1'b0 || pend_cnt !== 4'd1) begin bad++; $display("FAIL nto_hold got=%b/%0d want=0/1", seen, pend_cnt); end
    total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL nto_err got=%b want=0", rsp_err); end
    m_readdatavalid = 1'b1; m_readdata = 32'h22222222;
    @(negedge clk);
    m_readdatavalid = 1'b0;
    total++; if (s_readdatavalid !== 1'b1 || s_readdata !== 32'h22222222 || pend_cnt !== 4'd0) begin bad++; $display("FAIL nto_rsp got=%b/%h/%0d want=1/22222222/0", s_readdatavalid, s_readdata, pend_cnt); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    s_write = 1'b0; s_read = 1'b0; s_debugaccess = 1'b0;
    s_burstcount = '0; s_writedata = '0; s_address = '0; s_byteenable = '0;
    m_waitrequest = 1'b0; m_readdata = '0; m_readdatavalid = 1'b0;
    test_reset();
    test_write();
    test_back_to_back();
    test_burst_limit();
    test_simultaneous();
    test_edge_cases();
`ifdef AVMM_BRIDGE_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
